jtag_dtm: RTL

JTAG_DTM -- requirements
Module: jtag_dtm

---
 rtl/jtag_dtm.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/jtag_dtm.sv
// RISC-V style JTAG debug transport module: DTMCS/DMI data registers in the tck domain,
// bridged to a valid/ready DMI request/response pair driven by a three-state FSM.
module jtag_dtm #(
  parameter int          ABITS     = 7,
  parameter int          DR_WIDTH  = ABITS + 34,
  parameter logic [2:0]  IDLE_HINT = 3'd1
) (
  input  logic                tck_i,
  input  logic                trst_n_i,
  input  logic                cust_rg_addr_i,
  input  logic                cust_rg_val_i,
  input  logic [DR_WIDTH-1:0] cust_rg_dat_i,
  output logic [DR_WIDTH-1:0] cust_rg_dat_o,
  input  logic                cust_rg_dat_re_i,
  input  logic                cust_rg_dat_we_i,
  output logic                dmi_req_valid_o,
  input  logic                dmi_req_ready_i,
  output logic [ABITS-1:0]    dmi_req_addr_o,
  output logic [31:0]         dmi_req_data_o,
  output logic [1:0]          dmi_req_op_o,
  input  logic                dmi_rsp_valid_i,
  output logic                dmi_rsp_ready_o,
  input  logic [31:0]         dmi_rsp_data_i,
  input  logic [1:0]          dmi_rsp_op_i
);

  // Handshakes: a transfer happens on the rising tck edge where valid and ready are both 1;
  // valid never waits on ready and its payload is held stable until that edge.
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT_RSP = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [1:0]       dmistat_q, dmistat_d;
  logic [ABITS-1:0] last_addr_q, last_addr_d;
  logic [31:0]      last_data_q, last_data_d;
  logic [ABITS-1:0] req_addr_q, req_addr_d;
  logic [31:0]      req_data_q, req_data_d;
  logic [1:0]       req_op_q, req_op_d;

  logic             cap_dmi, wr_dmi, wr_dtmcs;
  logic [1:0]       dr_op, cap_op;
  logic [31:0]      dr_data;
  logic [ABITS-1:0] dr_addr;
  logic             unused_dat;

  assign cap_dmi  = cust_rg_val_i & cust_rg_dat_re_i & cust_rg_addr_i;
  assign wr_dmi   = cust_rg_val_i & cust_rg_dat_we_i & cust_rg_addr_i;
  assign wr_dtmcs = cust_rg_val_i & cust_rg_dat_we_i & ~cust_rg_addr_i;
  assign dr_op    = cust_rg_dat_i[1:0];
  assign dr_data  = cust_rg_dat_i[33:2];
  assign dr_addr  = cust_rg_dat_i[ABITS+33:34];
  assign unused_dat = ^cust_rg_dat_i;

  assign cap_op = (dmistat_q != 2'd0) ? dmistat_q :
                  (state_q != IDLE)   ? 2'd3 : 2'd0;

  always_comb begin
    cust_rg_dat_o = '0;
    if (cust_rg_addr_i) begin
      cust_rg_dat_o[ABITS+33:0] = {last_addr_q, last_data_q, cap_op};
    end else begin
      cust_rg_dat_o[14:0] = {IDLE_HINT, dmistat_q, 6'(ABITS), 4'd1};
    end
  end

  always_ff @(posedge tck_i or negedge trst_n_i) begin
    if (!trst_n_i) begin
      state_q     <= IDLE;
      dmistat_q   <= 2'd0;
      last_addr_q <= '0;
      last_data_q <= '0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_op_q    <= '0;
    end else begin
      state_q     <= state_d;
      dmistat_q   <= dmistat_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      req_addr_q  <= req_addr_d;
      req_data_q  <= req_data_d;
      req_op_q    <= req_op_d;
    end
  end

  // Later assignments take priority: handshakes, then capture-busy, then DR writes,
  // so a hard reset overrides a response arriving on the same edge.
  always_comb begin
    state_d     = state_q;
    dmistat_d   = dmistat_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    req_addr_d  = req_addr_q;
    req_data_d  = req_data_q;
    req_op_d    = req_op_q;

    case (state_q)
      REQ: if (dmi_req_ready_i) state_d = WAIT_RSP;
      WAIT_RSP: begin
        if (dmi_rsp_valid_i) begin
          state_d = IDLE;
          if (dmi_rsp_op_i == 2'd0) begin
            last_data_d = dmi_rsp_data_i;
          end else if (dmistat_q == 2'd0) begin
            dmistat_d = (dmi_rsp_op_i == 2'd3) ? 2'd3 : 2'd2;
          end
        end
      end
      default: ;
    endcase

    if (cap_dmi && state_q != IDLE && dmistat_q == 2'd0) dmistat_d = 2'd3;

    if (wr_dmi) begin
      if (state_q != IDLE) begin
        if (dmistat_q == 2'd0) dmistat_d = 2'd3;
      end else if (dmistat_q == 2'd0 && (dr_op == 2'd1 || dr_op == 2'd2)) begin
        state_d     = REQ;
        req_addr_d  = dr_addr;
        req_data_d  = dr_data;
        req_op_d    = dr_op;
        last_addr_d = dr_addr;
      end
    end

    if (wr_dtmcs) begin
      if (cust_rg_dat_i[17]) begin
        state_d     = IDLE;
        dmistat_d   = 2'd0;
        last_data_d = last_data_q;
      end else if (cust_rg_dat_i[16]) begin
        dmistat_d = 2'd0;
      end
    end
  end

  assign dmi_req_valid_o = (state_q == REQ);
  assign dmi_rsp_ready_o = (state_q == WAIT_RSP);
  assign dmi_req_addr_o  = req_addr_q;
  assign dmi_req_data_o  = req_data_q;
  assign dmi_req_op_o    = req_op_q;

endmodule
